// File: rtl/wb_commit_queue_if.sv
// CSR request/acknowledge bus between the commit queue and the CSR unit.
interface wb_commit_queue_if #(
    parameter int DATA_W = 32,
    parameter int CSR_AW = 14
);
    logic              csr_req;
    logic              csr_we;
    logic [CSR_AW-1:0] csr_num;
    logic [DATA_W-1:0] csr_wmask;
    logic [DATA_W-1:0] csr_wvalue;
    logic              csr_ack;
    logic [DATA_W-1:0] csr_rvalue;

    modport master (
        output csr_req, csr_we, csr_num, csr_wmask, csr_wvalue,
        input  csr_ack, csr_rvalue
    );

    modport slave (
        input  csr_req, csr_we, csr_num, csr_wmask, csr_wvalue,
        output csr_ack, csr_rvalue
    );
endinterface

// File: rtl/wb_commit_queue.sv
// In-order writeback/commit queue: buffers retired ops from MEM and commits
// the head to the register file, the CSR unit, or a front-end flush.
module wb_commit_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int RF_AW  = 5,
    parameter int CSR_AW = 14
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ms2ws_valid,
    output logic              ws_allowin,
    input  logic [31:0]       in_pc,
    input  logic              in_gr_we,
    input  logic [RF_AW-1:0]  in_dest,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_csr_re,
    input  logic              in_csr_we,
    input  logic [CSR_AW-1:0] in_csr_num,
    input  logic [DATA_W-1:0] in_csr_wmask,
    input  logic [DATA_W-1:0] in_csr_wvalue,
    input  logic              in_ex,
    input  logic [5:0]        in_ecode,
    input  logic [8:0]        in_esubcode,
    input  logic              in_ertn,
    input  logic              in_refetch,
    wb_commit_queue_if.master csr,
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              ws_ex,
    output logic              ws_ertn_flush,
    output logic              ws_reflush,
    output logic [31:0]       ex_pc,
    output logic [5:0]        ex_ecode,
    output logic [8:0]        ex_esubcode,
    output logic [31:0]       flush_pc,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_we,
    output logic [RF_AW-1:0]  debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0]       pc;
        logic              gr_we;
        logic [RF_AW-1:0]  dest;
        logic [DATA_W-1:0] result;
        logic              csr_re;
        logic              csr_we;
        logic [CSR_AW-1:0] csr_num;
        logic [DATA_W-1:0] csr_wmask;
        logic [DATA_W-1:0] csr_wvalue;
        logic              ex;
        logic [5:0]        ecode;
        logic [8:0]        esubcode;
        logic              ertn;
        logic              refetch;
    } entry_t;

    typedef enum logic [1:0] {IDLE, CSR_WAIT, FLUSH} state_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;

    entry_t head;
    entry_t in_e;
    logic   act, csr_acc, do_ex, do_ertn, commit, refl, flush, enq;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign in_e = '{pc: in_pc, gr_we: in_gr_we, dest: in_dest,
                    result: in_result, csr_re: in_csr_re,
                    csr_we: in_csr_we, csr_num: in_csr_num,
                    csr_wmask: in_csr_wmask, csr_wvalue: in_csr_wvalue,
                    ex: in_ex, ecode: in_ecode, esubcode: in_esubcode,
                    ertn: in_ertn, refetch: in_refetch};

    assign ws_allowin = resetn && (count_q != FULL) && (state_q != FLUSH);
    assign enq        = ms2ws_valid && ws_allowin;

    // Exceptions and ertn take priority over any CSR access at the head.
    always_comb begin
        head    = mem_q[head_q];
        act     = (count_q != '0) && (state_q != FLUSH);
        do_ex   = act && head.ex;
        do_ertn = act && !head.ex && head.ertn;
        csr_acc = act && !head.ex && !head.ertn
                  && (head.csr_re || head.csr_we);
        commit  = act && !head.ex && !head.ertn
                  && (!(head.csr_re || head.csr_we) || csr.csr_ack);
        refl    = commit && head.refetch;
        flush   = do_ex || do_ertn || refl;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = FLUSH;
        end else begin
            if (enq)    tail_d = nxt(tail_q);
            if (commit) head_d = nxt(head_q);
            count_d = count_q + CW'(enq) - CW'(commit);
            state_d = (csr_acc && !csr.csr_ack) ? CSR_WAIT : IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Payload storage needs no reset: every output is gated by occupancy.
    always_ff @(posedge clk) begin
        if (enq) mem_q[tail_q] <= in_e;
    end

    assign csr.csr_req    = csr_acc;
    assign csr.csr_we     = csr_acc && head.csr_we;
    assign csr.csr_num    = csr_acc ? head.csr_num : '0;
    assign csr.csr_wmask  = csr_acc ? head.csr_wmask : '0;
    assign csr.csr_wvalue = csr_acc ? head.csr_wvalue : '0;

    assign rf_we    = commit && head.gr_we;
    assign rf_waddr = rf_we ? head.dest : '0;
    assign rf_wdata = !rf_we      ? '0 :
                      head.csr_re ? csr.csr_rvalue : head.result;

    assign ws_ex         = do_ex;
    assign ws_ertn_flush = do_ertn;
    assign ws_reflush    = flush;
    assign ex_pc         = do_ex ? head.pc : '0;
    assign ex_ecode      = do_ex ? head.ecode : '0;
    assign ex_esubcode   = do_ex ? head.esubcode : '0;
    assign flush_pc      = do_ex ? head.pc :
                           refl  ? head.pc + 32'd4 : '0;

    assign debug_wb_pc       = (count_q != '0) ? head.pc : '0;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue: DEPTH=2 instance (table vectors,
// reset in CSR wait) and DEPTH=3 instance (exception flush, wrap-around).
module tb_wb_commit_queue;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        v = 0, gwe = 0, cre = 0, cwe = 0, ex = 0, ertn = 0, rfe = 0;
    logic [31:0] pc = 0, res = 0, cwm = 0, cwv = 0, rv = 0;
    logic [4:0]  dst = 0;
    logic [13:0] cnum = 0;
    logic [5:0]  ec = 0;
    logic [8:0]  esc = 0;
    logic        ack = 0;

    wb_commit_queue_if #(.DATA_W(32), .CSR_AW(14)) ifa ();
    wb_commit_queue_if #(.DATA_W(32), .CSR_AW(14)) ifb ();
    assign ifa.csr_ack = ack;
    assign ifa.csr_rvalue = rv;
    assign ifb.csr_ack = ack;
    assign ifb.csr_rvalue = rv;

    logic allow_a, rfwe_a, wsex_a, ertn_a, refl_a;
    logic [4:0] rfwa_a, dwn_a;
    logic [31:0] rfwd_a, expc_a, fpc_a, dpc_a, dwd_a;
    logic [5:0] exec_a;
    logic [8:0] exsc_a;
    logic [3:0] dwe_a;

    logic allow_b, rfwe_b, wsex_b, ertn_b, refl_b;
    logic [4:0] rfwa_b, dwn_b;
    logic [31:0] rfwd_b, expc_b, fpc_b, dpc_b, dwd_b;
    logic [5:0] exec_b;
    logic [8:0] exsc_b;
    logic [3:0] dwe_b;

    wb_commit_queue #(.DEPTH(2)) dut_a (
        .clk(clk), .resetn(resetn), .ms2ws_valid(v), .ws_allowin(allow_a),
        .in_pc(pc), .in_gr_we(gwe), .in_dest(dst), .in_result(res),
        .in_csr_re(cre), .in_csr_we(cwe), .in_csr_num(cnum),
        .in_csr_wmask(cwm), .in_csr_wvalue(cwv), .in_ex(ex),
        .in_ecode(ec), .in_esubcode(esc), .in_ertn(ertn),
        .in_refetch(rfe), .csr(ifa), .rf_we(rfwe_a), .rf_waddr(rfwa_a),
        .rf_wdata(rfwd_a), .ws_ex(wsex_a), .ws_ertn_flush(ertn_a),
        .ws_reflush(refl_a), .ex_pc(expc_a), .ex_ecode(exec_a),
        .ex_esubcode(exsc_a), .flush_pc(fpc_a), .debug_wb_pc(dpc_a),
        .debug_wb_rf_we(dwe_a), .debug_wb_rf_wnum(dwn_a),
        .debug_wb_rf_wdata(dwd_a)
    );

    wb_commit_queue #(.DEPTH(3)) dut_b (
        .clk(clk), .resetn(resetn), .ms2ws_valid(v), .ws_allowin(allow_b),
        .in_pc(pc), .in_gr_we(gwe), .in_dest(dst), .in_result(res),
        .in_csr_re(cre), .in_csr_we(cwe), .in_csr_num(cnum),
        .in_csr_wmask(cwm), .in_csr_wvalue(cwv), .in_ex(ex),
        .in_ecode(ec), .in_esubcode(esc), .in_ertn(ertn),
        .in_refetch(rfe), .csr(ifb), .rf_we(rfwe_b), .rf_waddr(rfwa_b),
        .rf_wdata(rfwd_b), .ws_ex(wsex_b), .ws_ertn_flush(ertn_b),
        .ws_reflush(refl_b), .ex_pc(expc_b), .ex_ecode(exec_b),
        .ex_esubcode(exsc_b), .flush_pc(fpc_b), .debug_wb_pc(dpc_b),
        .debug_wb_rf_we(dwe_b), .debug_wb_rf_wnum(dwn_b),
        .debug_wb_rf_wdata(dwd_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the edge, return at mid-cycle.
    task automatic set_in(input logic v_, input logic [31:0] pc_,
                          input logic [4:0] dst_, input logic [31:0] res_,
                          input logic cre_, input logic ex_, input logic rf_,
                          input logic ack_, input logic [31:0] rv_);
        @(posedge clk);
        #1;
        v = v_; pc = pc_; gwe = v_; dst = dst_; res = res_;
        cre = cre_; cnum = cre_ ? 14'h00C : 14'h0;
        ex = ex_; ec = ex_ ? 6'h0B : 6'h0; rfe = rf_;
        ack = ack_; rv = rv_;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 0;
        v = 0; ack = 0; cre = 0; ex = 0; rfe = 0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1;
    endtask

    typedef struct {
        logic v; logic [31:0] pc; logic [4:0] dst; logic [31:0] res;
        logic cre; logic rf; logic ack; logic [31:0] rv;
        logic ea; logic ew; logic [4:0] ewa; logic [31:0] ewd;
        logic eq; logic erf; logic [31:0] efp;
    } vec_t;

    function automatic vec_t mk(
        input logic v_, input logic [31:0] pc_, input logic [4:0] dst_,
        input logic [31:0] res_, input logic cre_, input logic rf_,
        input logic ack_, input logic [31:0] rv_, input logic ea_,
        input logic ew_, input logic [4:0] ewa_, input logic [31:0] ewd_,
        input logic eq_, input logic erf_, input logic [31:0] efp_);
        vec_t r;
        r.v = v_; r.pc = pc_; r.dst = dst_; r.res = res_; r.cre = cre_;
        r.rf = rf_; r.ack = ack_; r.rv = rv_; r.ea = ea_; r.ew = ew_;
        r.ewa = ewa_; r.ewd = ewd_; r.eq = eq_; r.erf = erf_; r.efp = efp_;
        return r;
    endfunction

    vec_t tbl[$];
    logic [4:0]  exp_a[$];
    logic [31:0] exp_d[$];

    initial begin
        // back-to-back ALU ops
        tbl.push_back(mk(1, 32'h1C000000, 1, 32'h11, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h1C000004, 2, 32'h22, 0, 0, 0, 0, 1, 1, 1, 32'h11, 0, 0, 0));
        tbl.push_back(mk(1, 32'h1C000008, 3, 32'h33, 0, 0, 0, 0, 1, 1, 2, 32'h22, 0, 0, 0));
        tbl.push_back(mk(1, 32'h1C00000C, 4, 32'h44, 0, 0, 0, 0, 1, 1, 3, 32'h33, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 32'h44, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // CSR read, ack three cycles after the first request
        tbl.push_back(mk(1, 32'h1C000020, 5, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h1C000024, 6, 32'h66, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h1C000028, 7, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h1C000028, 7, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h1C000028, 7, 32'h77, 0, 0, 1, 32'hDEADBEEF,
                         0, 1, 5, 32'hDEADBEEF, 1, 0, 0));
        tbl.push_back(mk(1, 32'h1C000028, 7, 32'h77, 0, 0, 0, 0, 1, 1, 6, 32'h66, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 32'h77, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // refetch with a simultaneous enqueue that must be discarded
        tbl.push_back(mk(1, 32'h1C000100, 7, 32'h70, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h1C000104, 9, 32'h99, 0, 0, 0, 0,
                         1, 1, 7, 32'h70, 0, 1, 32'h1C000104));
        tbl.push_back(mk(1, 32'h1C000104, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        #2;
        chk("rst allowin", 32'(allow_a), 0);
        chk("rst rf_we", 32'(rfwe_a), 0);
        chk("rst csr_req", 32'(ifa.csr_req), 0);
        chk("rst dbg_pc", dpc_a, 0);
        chk("rst reflush", 32'(refl_a), 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        chk("post-rst allowin", 32'(allow_a), 1);

        foreach (tbl[i]) begin
            set_in(tbl[i].v, tbl[i].pc, tbl[i].dst, tbl[i].res,
                   tbl[i].cre, 1'b0, tbl[i].rf, tbl[i].ack, tbl[i].rv);
            chk($sformatf("r%0d allowin", i), 32'(allow_a), 32'(tbl[i].ea));
            chk($sformatf("r%0d rf_we", i), 32'(rfwe_a), 32'(tbl[i].ew));
            chk($sformatf("r%0d rf_waddr", i), 32'(rfwa_a), 32'(tbl[i].ewa));
            chk($sformatf("r%0d rf_wdata", i), rfwd_a, tbl[i].ewd);
            chk($sformatf("r%0d dbg_we", i), 32'(dwe_a), tbl[i].ew ? 32'hF : 32'h0);
            chk($sformatf("r%0d csr_req", i), 32'(ifa.csr_req), 32'(tbl[i].eq));
            chk($sformatf("r%0d csr_num", i), 32'(ifa.csr_num),
                tbl[i].eq ? 32'h00C : 32'h0);
            chk($sformatf("r%0d reflush", i), 32'(refl_a), 32'(tbl[i].erf));
            chk($sformatf("r%0d flush_pc", i), fpc_a, tbl[i].efp);
            chk($sformatf("r%0d ws_ex", i), 32'(wsex_a), 0);
        end

        // exception at head with one entry behind and one arriving (DEPTH=3)
        do_reset();
        set_in(1, 32'h1C00000C, 8, 0, 1, 0, 0, 0, 0);
        set_in(1, 32'h1C000010, 0, 0, 0, 1, 0, 0, 0);
        chk("ex csr_req", 32'(ifb.csr_req), 1);
        set_in(1, 32'h1C000014, 9, 32'h99, 0, 0, 0, 0, 0);
        chk("ex fill allowin", 32'(allow_b), 1);
        set_in(1, 32'h1C000018, 10, 32'hAA, 0, 0, 0, 1, 32'h1234);
        chk("ex full allowin", 32'(allow_b), 0);
        chk("ex csr commit we", 32'(rfwe_b), 1);
        chk("ex csr commit data", rfwd_b, 32'h1234);
        set_in(1, 32'h1C000018, 10, 32'hAA, 0, 0, 0, 0, 0);
        chk("ex pulse", 32'(wsex_b), 1);
        chk("ex reflush", 32'(refl_b), 1);
        chk("ex ex_pc", expc_b, 32'h1C000010);
        chk("ex ecode", 32'(exec_b), 32'h0B);
        chk("ex flush_pc", fpc_b, 32'h1C000010);
        chk("ex no rf_we", 32'(rfwe_b), 0);
        chk("ex no csr_req", 32'(ifb.csr_req), 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ex flush allowin", 32'(allow_b), 0);
        chk("ex one pulse", 32'(wsex_b), 0);
        chk("ex flush rf_we", 32'(rfwe_b), 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ex after allowin", 32'(allow_b), 1);
        chk("ex drained rf_we", 32'(rfwe_b), 0);
        chk("ex drained dbg_pc", dpc_b, 0);

        // reset while waiting on a CSR ack (DEPTH=2)
        do_reset();
        set_in(1, 32'h1C000020, 5, 0, 1, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wait csr_req", 32'(ifa.csr_req), 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wait csr_req held", 32'(ifa.csr_req), 1);
        chk("wait dbg_pc", dpc_a, 32'h1C000020);
        #2;
        resetn = 0;
        #1;
        chk("arst csr_req", 32'(ifa.csr_req), 0);
        chk("arst csr_num", 32'(ifa.csr_num), 0);
        chk("arst allowin", 32'(allow_a), 0);
        chk("arst dbg_pc", dpc_a, 0);
        chk("arst rf_we", 32'(rfwe_a), 0);
        @(negedge clk);
        resetn = 1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rel allowin", 32'(allow_a), 1);
        chk("rel csr_req", 32'(ifa.csr_req), 0);
        chk("rel rf_we", 32'(rfwe_a), 0);

        // wrap-around with random input and ack stalls (DEPTH=3)
        do_reset();
        begin
            int sent = 0;
            int got = 0;
            for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
                logic vv;
                logic cc;
                vv = (sent < 10) && ($urandom_range(0, 1) == 1);
                cc = (sent % 3) == 1;
                set_in(vv, 32'h1C001000 + 32'(sent * 4), 5'(sent + 1),
                       32'h100 + 32'(sent), cc, 0, 0,
                       $urandom_range(0, 2) == 0, 32'hCAFEF00D);
                if (rfwe_b) begin
                    if (exp_a.size() == 0) begin
                        chk("wrap spurious commit", 32'(rfwa_b), 32'h0);
                    end else begin
                        chk($sformatf("wrap%0d waddr", got), 32'(rfwa_b),
                            32'(exp_a.pop_front()));
                        chk($sformatf("wrap%0d wdata", got), rfwd_b,
                            exp_d.pop_front());
                    end
                    got++;
                end
                if (vv && allow_b) begin
                    exp_a.push_back(5'(sent + 1));
                    exp_d.push_back(cc ? 32'hCAFEF00D : 32'h100 + 32'(sent));
                    sent++;
                end
            end
            chk("wrap commits", 32'(got), 32'd10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_commit_queue.md
# wb_commit_queue

Parametrised writeback/commit stage between MEM and the register file/CSR unit. It buffers up to DEPTH retired instructions in an in-order queue and commits the head entry. Commit writes the register file, performs a CSR access over a req/ack handshake, or raises an exception/ertn/refetch flush to the front of the pipe. It replaces the fixed single-entry, zero-wait writeback stage.

## Interface
Parameters:
- DATA_W, 32: GPR/CSR data width.
- DEPTH, 2: queue entries, at least 1 (a power of two is not required).
- RF_AW, 5: register address width.
- CSR_AW, 14: CSR number width.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock.
- resetn  in  1  async active-low reset.
- ms2ws_valid  in  1  MEM presents an instruction.
- ws_allowin  out  1  queue accepts this cycle.
- in_pc  in  32  instruction PC.
- in_gr_we, in_dest  in  1, RF_AW  GPR write enable and address.
- in_result  in  DATA_W  ALU/load result.
- in_csr_re, in_csr_we  in  1, 1  CSR read, CSR write.
- in_csr_num, in_csr_wmask, in_csr_wvalue  in  CSR_AW, DATA_W, DATA_W  CSR access fields.
- in_ex, in_ecode, in_esubcode  in  1, 6, 9  exception flag and codes.
- in_ertn, in_refetch  in  1, 1  ertn; refetch-after-commit.
- csr_req  out  1  CSR access request.
- csr_we, csr_num, csr_wmask, csr_wvalue  out  1, CSR_AW, DATA_W, DATA_W  request fields.
- csr_ack  in  1  access done; csr_rvalue valid this cycle.
- csr_rvalue  in  DATA_W  CSR read data.
- rf_we, rf_waddr, rf_wdata  out  1, RF_AW, DATA_W  GPR write port.
- ws_ex, ws_ertn_flush, ws_reflush  out  1 each  one-cycle flush pulses.
- ex_pc, ex_ecode, ex_esubcode  out  32, 6, 9  exception info, valid with ws_ex.
- flush_pc  out  32  refetch target, valid with ws_reflush.
- debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata  out  32, 4, RF_AW, DATA_W  trace.

## Operation
- Circular queue: head pointer, tail pointer and count register with range 0..DEPTH. Pointers wrap at DEPTH-1 → 0.
- ws_allowin = (count != DEPTH) && state != FLUSH.
- Enqueue on ms2ws_valid && ws_allowin. An entry cannot enter and commit in the same cycle.
- The FSM acts only when the queue is non-empty. States:
  - IDLE: examine the head.
    - in_ex: pulse ws_ex and ws_reflush; flush_pc = ex_pc = head pc; no RF write, no csr_req. Go to FLUSH.
    - in_ertn: pulse ws_ertn_flush and ws_reflush. Go to FLUSH.
    - csr_re or csr_we: assert csr_req. If csr_ack arrives the same cycle, commit; otherwise go to CSR_WAIT.
    - Otherwise: commit.
  - CSR_WAIT: hold csr_req and all request fields stable until csr_ack, then commit and go to IDLE.
  - FLUSH: lasts one cycle; ws_allowin = 0, then go to IDLE.
- Commit (any path):
  - rf_we = gr_we; rf_wdata = csr_rvalue if csr_re, else result.
  - Pop the head.
  - If refetch, also pulse ws_reflush with flush_pc = pc + 4 and go to FLUSH.
- Any flush pulse clears the whole queue (count = 0) at that edge. This includes an entry enqueued in the same cycle, which is discarded.
- debug_wb_pc = head pc; debug_wb_rf_we = {4{rf_we}}; debug_wb_rf_wnum/wdata mirror rf_waddr/rf_wdata.

## Timing
- Reset (async assert, sync deassert upstream): count = 0, pointers = 0, state = IDLE. All outputs are 0; ws_allowin = 1 in the first cycle after deassert.
- Latency: an entry enqueued at edge N has rf_we high during cycle N→N+1 when it is the head and needs no CSR access.
- Throughput: one commit per cycle with no CSR waits. When full, ws_allowin drops in the same cycle count reaches DEPTH.
- CSR: commit occurs in the csr_ack cycle; csr_req deasserts after that edge. The number of wait cycles is unbounded.
- The flush pulse is combinational in the commit/detect cycle and lasts exactly one cycle. The following cycle is FLUSH with allowin = 0.
- Reset during CSR_WAIT drops the request immediately (csr_req = 0).

## Test plan
- Back-to-back: 4 ALU ops (dest r1..r4, results 0x11..0x44) on consecutive cycles → rf_we every cycle, in order, starting 1 cycle after the first enqueue.
- CSR read with 3-cycle ack delay, csr_rvalue = 0xDEAD_BEEF, dest r5 → csr_req held for 4 cycles; r5 = 0xDEADBEEF written in the ack cycle; with DEPTH = 2, two followers fill the queue and ws_allowin = 0.
- Exception at head (pc 0x1C000010, ecode 0x0B) with a valid entry behind it and a simultaneous enqueue → one ws_ex pulse with ex_pc = 0x1C000010; no rf_we; count = 0; next cycle ws_allowin = 0, then 1.
- Refetch entry (pc 0x1C000100, gr_we to r7) → r7 written and ws_reflush with flush_pc = 0x1C000104 in the same cycle.
- resetn asserted mid CSR_WAIT → all outputs 0 asynchronously; after release, a queue-empty idle state with ws_allowin = 1.
- DEPTH = 3: wrap-around across 10 enqueues with random stalls → commit order matches enqueue order.
